// File: rtl/mmio_uart_fifo.sv
`default_nettype none
// =============================================================================
// mmio_uart_fifo : MMIO responder with FIFO-buffered 8N1 UART, status and
//                  cycle/instret counters. Define MMIO_UART_LOOPBACK_EN to feed
//                  serial_out back into the receiver.
// Revision       : 1.0
// =============================================================================

module mmio_uart_fifo_buf #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic [7:0]          data_i,
  input  logic                pop_i,
  output logic [7:0]          data_o,
  output logic                empty_o,
  output logic                full_o,
  output logic [DEPTH_LOG2:0] count_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q;
  logic [DEPTH_LOG2-1:0] rd_ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  w_push;
  logic                  w_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (DEPTH_LOG2+1)'(DEPTH));
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  // Push is refused when full even if a pop happens this cycle; pop on empty is a no-op.
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + (DEPTH_LOG2+1)'(1);
        2'b01:   count_q <= count_q - (DEPTH_LOG2+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

module mmio_uart_fifo #(
  parameter int CPU_CLOCK_FREQ  = 50_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [31:0] din,
  input  logic        iflag,
  output logic [31:0] dout,
  input  logic        serial_in,
  output logic        serial_out
);
  localparam int CLKS_PER_BIT = CPU_CLOCK_FREQ / BAUD_RATE;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam int NW           = FIFO_DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [5:0] A_STATUS  = 6'h00;
  localparam logic [5:0] A_RXDATA  = 6'h01;
  localparam logic [5:0] A_TXDATA  = 6'h02;
  localparam logic [5:0] A_LEVELS  = 6'h03;
  localparam logic [5:0] A_CYCLES  = 6'h04;
  localparam logic [5:0] A_INSTRET = 6'h05;
  localparam logic [5:0] A_CLEAR   = 6'h06;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

  logic [5:0]  w_idx;
  logic        w_rd;
  logic        w_wr;
  logic        w_unused;
  assign w_idx    = addr[7:2];
  assign w_rd     = en & ~we;
  assign w_wr     = en & we;
  assign w_unused = ^{din[31:8], addr[1:0]};

  logic          w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
  logic [7:0]    w_tx_head;
  logic [NW-1:0] w_tx_count;
  logic          w_rx_pop, w_rx_empty, w_rx_full;
  logic [7:0]    w_rx_head;
  logic [NW-1:0] w_rx_count;

  uart_state_e   tx_state_q;
  logic [CW-1:0] tx_cnt_q;
  logic [2:0]    tx_bit_q;
  logic [7:0]    tx_shift_q;
  logic          tx_line_q;
  logic          w_tx_bit_end;

  uart_state_e   rx_state_q;
  logic [CW-1:0] rx_cnt_q;
  logic [2:0]    rx_bit_q;
  logic [7:0]    rx_shift_q;
  logic          rx_done_q;
  logic          rx_ferr_q;
  logic          sync1_q, sync2_q;
  logic          w_rx_in;
  logic          w_rxd;
  logic          w_rx_bit_end;

  logic          ovr_q, ferr_q;
  logic          w_status_rd;
  logic          w_clear;
  logic [31:0]   cycles_q, instret_q;
  logic [31:0]   dout_q, dout_d;

  assign w_tx_push = w_wr & (w_idx == A_TXDATA);
  assign w_rx_pop  = w_rd & (w_idx == A_RXDATA);

  mmio_uart_fifo_buf #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_tx_push),
    .data_i  (din[7:0]),
    .pop_i   (w_tx_pop),
    .data_o  (w_tx_head),
    .empty_o (w_tx_empty),
    .full_o  (w_tx_full),
    .count_o (w_tx_count)
  );

  mmio_uart_fifo_buf #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (rx_done_q),
    .data_i  (rx_shift_q),
    .pop_i   (w_rx_pop),
    .data_o  (w_rx_head),
    .empty_o (w_rx_empty),
    .full_o  (w_rx_full),
    .count_o (w_rx_count)
  );

  // Transmitter takes a byte from IDLE or at the end of STOP, giving gapless frames.
  assign w_tx_bit_end = (tx_cnt_q == BIT_LAST);
  assign w_tx_pop     = ~w_tx_empty & ((tx_state_q == S_IDLE) |
                                       ((tx_state_q == S_STOP) & w_tx_bit_end));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: begin
          if (!w_tx_empty) begin
            tx_state_q <= S_START;
            tx_shift_q <= w_tx_head;
            tx_cnt_q   <= '0;
            tx_line_q  <= 1'b0;
          end
        end
        S_START: begin
          if (w_tx_bit_end) begin
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_state_q <= S_DATA;
            tx_line_q  <= tx_shift_q[0];
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (w_tx_bit_end) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 3'd7) begin
              tx_state_q <= S_STOP;
              tx_line_q  <= 1'b1;
            end else begin
              tx_bit_q   <= tx_bit_q + 3'd1;
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_line_q  <= tx_shift_q[1];
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (w_tx_bit_end) begin
            tx_cnt_q <= '0;
            if (!w_tx_empty) begin
              tx_state_q <= S_START;
              tx_shift_q <= w_tx_head;
              tx_line_q  <= 1'b0;
            end else begin
              tx_state_q <= S_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + CW'(1);
          end
        end
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MMIO_UART_LOOPBACK_EN
  logic w_unused_serial_in;
  assign w_unused_serial_in = serial_in;
  assign w_rx_in            = tx_line_q;
`else
  assign w_rx_in = serial_in;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= w_rx_in;
      sync2_q <= sync1_q;
    end
  end
  assign w_rxd        = sync2_q;
  assign w_rx_bit_end = (rx_cnt_q == BIT_LAST);

  // Start bit is re-checked half a bit in; later samples land one bit apart at mid-bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_done_q  <= 1'b0;
      rx_ferr_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      rx_ferr_q <= 1'b0;
      case (rx_state_q)
        S_IDLE: begin
          if (!w_rxd) begin
            rx_state_q <= S_START;
            rx_cnt_q   <= '0;
          end
        end
        S_START: begin
          if (rx_cnt_q == HALF_LAST) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= w_rxd ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (w_rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {w_rxd, rx_shift_q[7:1]};
            if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (w_rx_bit_end) begin
            rx_cnt_q   <= '0;
            rx_state_q <= S_IDLE;
            rx_done_q  <= w_rxd;
            rx_ferr_q  <= ~w_rxd;
          end else begin
            rx_cnt_q <= rx_cnt_q + CW'(1);
          end
        end
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

  assign w_status_rd = w_rd & (w_idx == A_STATUS);
  assign w_clear     = w_wr & (w_idx == A_CLEAR);

  always_comb begin
    dout_d = '0;
    case (w_idx)
      A_STATUS:  dout_d = {28'b0, ovr_q, ferr_q, ~w_rx_empty, ~w_tx_full};
      A_RXDATA:  dout_d = {24'b0, (w_rx_empty ? 8'h00 : w_rx_head)};
      A_LEVELS:  dout_d = {8'b0, 8'(w_tx_count), 8'b0, 8'(w_rx_count)};
      A_CYCLES:  dout_d = cycles_q;
      A_INSTRET: dout_d = instret_q;
      default:   dout_d = '0;
    endcase
  end

  // Sticky flags: a set in the same cycle as a STATUS read survives the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovr_q     <= 1'b0;
      ferr_q    <= 1'b0;
      cycles_q  <= '0;
      instret_q <= '0;
      dout_q    <= '0;
    end else begin
      ovr_q     <= (rx_done_q & w_rx_full) | (ovr_q & ~w_status_rd);
      ferr_q    <= rx_ferr_q | (ferr_q & ~w_status_rd);
      cycles_q  <= w_clear ? 32'd0 : cycles_q + 32'd1;
      instret_q <= w_clear ? 32'd0 : instret_q + {31'b0, iflag};
      if (w_rd) dout_q <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign serial_out = tx_line_q;
endmodule

`default_nettype wire

// File: tb/tb_mmio_uart_fifo.sv
`default_nettype none
// =============================================================================
// tb_mmio_uart_fifo : directed/randomized bench for mmio_uart_fifo with a
//                     queue-based reference model and serial line monitor.
// Revision          : 1.0
// =============================================================================
module tb_mmio_uart_fifo;
  localparam int CLK_HZ = 80;
  localparam int BAUD   = 10;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int DEPTH  = 8;

  localparam logic [7:0] R_STATUS  = 8'h00;
  localparam logic [7:0] R_RXDATA  = 8'h04;
  localparam logic [7:0] R_TXDATA  = 8'h08;
  localparam logic [7:0] R_LEVELS  = 8'h0C;
  localparam logic [7:0] R_CYCLES  = 8'h10;
  localparam logic [7:0] R_INSTRET = 8'h14;
  localparam logic [7:0] R_CLEAR   = 8'h18;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        we = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] din = '0;
  logic        iflag = 1'b0;
  logic        serial_in = 1'b1;
  logic [31:0] dout;
  logic        serial_out;

  mmio_uart_fifo #(
    .CPU_CLOCK_FREQ  (CLK_HZ),
    .BAUD_RATE       (BAUD),
    .FIFO_DEPTH_LOG2 (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .we         (we),
    .addr       (addr),
    .din        (din),
    .iflag      (iflag),
    .dout       (dout),
    .serial_in  (serial_in),
    .serial_out (serial_out)
  );

  always #5 clk = ~clk;

  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Serial line monitor: decodes frames at mid-bit and records each start edge.
  bit         mon_en = 1'b0;
  logic [7:0] tx_got[$];
  int         tx_start[$];
  int         tx_bad = 0;

  initial begin : monitor
    logic [7:0] b;
    int         st;
    bit         ok;
    forever begin
      @(negedge clk);
      if (mon_en && rst && serial_out === 1'b0) begin
        st = ecnt;
        ok = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        if (serial_out !== 1'b0) ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = serial_out;
        end
        repeat (CPB) @(negedge clk);
        if (serial_out !== 1'b1) ok = 1'b0;
        tx_got.push_back(b);
        tx_start.push_back(st);
        if (!ok) tx_bad++;
      end
    end
  end

  // Bus tasks start and end at a falling edge so consecutive calls are back-to-back.
  task automatic mmio_write(input logic [7:0] a, input logic [31:0] d, output int wedge);
    en = 1'b1; we = 1'b1; addr = a; din = d;
    wedge = ecnt + 1;
    @(negedge clk);
    en = 1'b0; we = 1'b0;
  endtask

  task automatic mmio_read(input logic [7:0] a, output logic [31:0] d, output int redge);
    en = 1'b1; we = 1'b0; addr = a;
    redge = ecnt + 1;
    @(negedge clk);
    en = 1'b0;
    d = dout;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // A bad stop bit is cut short after its mid-point so the line is idle again early.
  task automatic uart_send(input logic [7:0] b, input bit stop_ok);
    serial_in = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      repeat (CPB) @(negedge clk);
    end
    if (stop_ok) begin
      serial_in = 1'b1;
      repeat (CPB) @(negedge clk);
    end else begin
      serial_in = 1'b0;
      repeat (CPB / 2 + 1) @(negedge clk);
      serial_in = 1'b1;
      repeat (CPB / 2 - 1) @(negedge clk);
    end
  endtask

  logic [31:0] rd;
  logic [31:0] last;
  int          e, w, c;
  logic [7:0]  bytes[10];
  logic [7:0]  exp_tx[$];
  logic [7:0]  rx_model[$];
  logic [7:0]  rb;
  int          occ, npulse, gap;
  bit          busy, pop, push, ovr, lat_ok;

  initial begin
    // ---------------- reset behaviour ----------------
    idle(3);
    check("reset_dout", dout, 32'h0);
    check("reset_serial_out", {31'b0, serial_out}, 32'h1);
    rst = 1'b1;
    idle(1);
    mmio_read(R_STATUS, rd, e);  check("status_after_reset", rd, 32'h1);
    mmio_read(R_LEVELS, rd, e);  check("levels_after_reset", rd, 32'h0);

    mmio_write(R_TXDATA, 32'h00, w);
    mmio_write(R_TXDATA, $urandom, w);
    idle(3 * CPB);
    check("line_low_mid_frame", {31'b0, serial_out}, 32'h0);
    #2 rst = 1'b0;
    #1 check("async_reset_line_high", {31'b0, serial_out}, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    mmio_read(R_STATUS, rd, e);  check("status_after_midframe_reset", rd, 32'h1);
    mmio_read(R_LEVELS, rd, e);  check("levels_after_midframe_reset", rd, 32'h0);
    mon_en = 1'b1;
    idle(12 * CPB);
    check("no_frame_after_reset", tx_got.size(), 32'd0);

    // ---------------- single TX frames ----------------
    bytes[0] = 8'hA5;
    bytes[1] = 8'($urandom);
    bytes[2] = 8'($urandom);
    for (int k = 0; k < 3; k++) begin
      tx_got.delete(); tx_start.delete();
      mmio_write(R_TXDATA, {$urandom, bytes[k]} , w);
      idle(11 * CPB);
      check("tx_single_count", tx_got.size(), 32'd1);
      if (tx_got.size() == 1) begin
        check("tx_single_byte", {24'b0, tx_got[0]}, {24'b0, bytes[k]});
        lat_ok = (tx_start[0] - w >= 1) && (tx_start[0] - w <= 2);
        check("tx_start_latency", {31'b0, lat_ok}, 32'h1);
      end
    end

    // ---------------- TX burst past FIFO depth ----------------
    tx_got.delete(); tx_start.delete(); exp_tx.delete();
    for (int i = 0; i < 10; i++) bytes[i] = 8'($urandom);
    occ = 0; busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pop  = !busy && occ > 0;
      push = occ < DEPTH;
      if (push) exp_tx.push_back(bytes[i]);
      occ = occ + int'(push) - int'(pop);
      if (pop) busy = 1'b1;
      mmio_write(R_TXDATA, {24'b0, bytes[i]}, w);
    end
    mmio_read(R_LEVELS, rd, e);
    check("levels_tx_full", rd, {8'b0, 8'(occ), 16'b0});
    mmio_read(R_STATUS, rd, e);
    check("status_tx_full", rd, 32'h0);
    idle(exp_tx.size() * 10 * CPB + 20);
    check("tx_burst_count", tx_got.size(), exp_tx.size());
    for (int i = 0; i < exp_tx.size() && i < tx_got.size(); i++)
      check("tx_burst_byte", {24'b0, tx_got[i]}, {24'b0, exp_tx[i]});
    for (int i = 1; i < tx_start.size(); i++)
      check("tx_burst_gapless", tx_start[i] - tx_start[i-1], 10 * CPB);
    check("tx_framing_bits", tx_bad, 32'd0);
    mmio_read(R_STATUS, rd, e);  check("status_tx_drained", rd, 32'h1);

    // ---------------- RX good frame, framing error, glitch ----------------
    rb = 8'($urandom);
    uart_send(rb, 1'b1);
    idle(2);
    mmio_read(R_STATUS, rd, e);  check("status_rx_valid", rd, 32'h3);
    mmio_read(R_LEVELS, rd, e);  check("levels_rx_one", rd, 32'h1);
    mmio_read(R_RXDATA, rd, e);  check("rxdata_byte", rd, {24'b0, rb});
    mmio_read(R_STATUS, rd, e);  check("status_rx_empty", rd, 32'h1);

    uart_send(8'($urandom), 1'b0);
    idle(2 + CPB);
    mmio_read(R_STATUS, rd, e);  check("status_frame_err", rd, 32'h5);
    mmio_read(R_STATUS, rd, e);  check("status_frame_err_cleared", rd, 32'h1);
    mmio_read(R_LEVELS, rd, e);  check("levels_after_frame_err", rd, 32'h0);

    serial_in = 1'b0;
    idle(1);
    serial_in = 1'b1;
    idle(2 * CPB);
    mmio_read(R_STATUS, rd, e);  check("status_after_glitch", rd, 32'h1);

    // ---------------- RX overrun ----------------
    rx_model.delete(); ovr = 1'b0;
    for (int i = 0; i < 9; i++) begin
      rb = 8'($urandom);
      if (rx_model.size() < DEPTH) rx_model.push_back(rb);
      else                         ovr = 1'b1;
      uart_send(rb, 1'b1);
    end
    idle(2);
    mmio_read(R_STATUS, rd, e);
    check("status_overrun", rd, {28'b0, ovr, 1'b0, (rx_model.size() > 0), 1'b1});
    mmio_read(R_LEVELS, rd, e);
    check("levels_rx_full", rd, {24'b0, 8'(rx_model.size())});
    while (rx_model.size() > 0) begin
      mmio_read(R_RXDATA, rd, e);
      check("rxdata_fifo_order", rd, {24'b0, rx_model.pop_front()});
    end
    mmio_read(R_RXDATA, rd, e);  check("rxdata_empty_zero", rd, 32'h0);
    mmio_read(R_STATUS, rd, e);  check("status_after_drain", rd, 32'h1);

    // ---------------- counters ----------------
    mmio_write(R_CLEAR, $urandom, c);
    mmio_read(R_CYCLES, rd, e);  check("cycles_after_clear", rd, 32'(e - c - 1));
    gap = $urandom_range(3, 20);
    idle(gap);
    mmio_read(R_CYCLES, rd, e);  check("cycles_running", rd, 32'(e - c - 1));
    mmio_read(R_INSTRET, rd, e); check("instret_zero", rd, 32'h0);

    iflag = 1'b1;
    idle(10);
    iflag = 1'b0;
    mmio_read(R_INSTRET, rd, e); check("instret_ten", rd, 32'd10);
    npulse = 0;
    for (int i = 0; i < 20; i++) begin
      iflag = 1'($urandom);
      npulse += int'(iflag);
      idle(1);
    end
    iflag = 1'b0;
    mmio_read(R_INSTRET, rd, e); check("instret_random", rd, 32'(10 + npulse));

    iflag = 1'b1;
    idle(10);
    mmio_write(R_CLEAR, 32'h0, c);
    iflag = 1'b0;
    mmio_read(R_INSTRET, rd, e); check("instret_clear_wins", rd, 32'h0);
    mmio_read(R_CYCLES, rd, e);  check("cycles_restart", rd, 32'(e - c - 1));

    // ---------------- unmapped and hold ----------------
    mmio_read(8'h1C, rd, e);     check("unmapped_read", rd, 32'h0);
    mmio_read(R_TXDATA, rd, e);  check("txdata_reads_zero", rd, 32'h0);
    mmio_write(8'h20, $urandom, w);
    mmio_read(R_LEVELS, rd, e);  check("unmapped_write_ignored", rd, 32'h0);
    mmio_read(R_CYCLES, last, e);
    idle(5);
    check("dout_holds", dout, last);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
